// File: rtl/fifo_counted.sv
// fifo_counted: ready/valid FIFO of any depth (not only powers of two) in which every
// slot is usable. It reports its occupancy and has registered almost-full and
// almost-empty flags, a synchronous flush, and sticky overflow/underflow error flags.
// Storage is flop/LUT RAM with an asynchronous read port.
//
// Ports:
//   clk_i      clock, rising edge
//   reset_i    asynchronous, active-high reset
//   flush_i    synchronous clear of pointers, count and error flags
//   ready_o    FIFO can accept a word (count_o < depth_p)
//   valid_i    producer offers data_i
//   data_i     write data
//   valid_o    data_o holds the oldest word (count_o > 0)
//   data_o     oldest word, read combinationally from storage
//   yumi_i     consumer takes data_o this cycle
//   count_o    current occupancy, 0..depth_p
//   afull_o    count_o >= afull_lvl_p
//   aempty_o   count_o <= aempty_lvl_p
//   err_ovf_o  sticky: valid_i seen while ready_o=0
//   err_unf_o  sticky: yumi_i seen while valid_o=0
module fifo_counted #(
  parameter int width_p      = 8,
  parameter int depth_p      = 128,
  parameter int afull_lvl_p  = 120,
  parameter int aempty_lvl_p = 8
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         flush_i,
  output logic                         ready_o,
  input  logic                         valid_i,
  input  logic [width_p-1:0]           data_i,
  output logic                         valid_o,
  output logic [width_p-1:0]           data_o,
  input  logic                         yumi_i,
  output logic [$clog2(depth_p+1)-1:0] count_o,
  output logic                         afull_o,
  output logic                         aempty_o,
  output logic                         err_ovf_o,
  output logic                         err_unf_o
);

  localparam int ptr_w_lp = $clog2(depth_p);
  localparam int cnt_w_lp = $clog2(depth_p + 1);

  localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(depth_p - 1);
  localparam logic [cnt_w_lp-1:0] depth_lp    = cnt_w_lp'(depth_p);
  localparam logic [cnt_w_lp-1:0] afull_lp    = cnt_w_lp'(afull_lvl_p);
  localparam logic [cnt_w_lp-1:0] aempty_lp   = cnt_w_lp'(aempty_lvl_p);

  logic [width_p-1:0]  mem_q [depth_p];

  logic [ptr_w_lp-1:0] wr_ptr_q, wr_ptr_d;
  logic [ptr_w_lp-1:0] rd_ptr_q, rd_ptr_d;
  logic [cnt_w_lp-1:0] count_q, count_d;
  logic                afull_q, afull_d;
  logic                aempty_q, aempty_d;
  logic                err_ovf_q, err_ovf_d;
  logic                err_unf_q, err_unf_d;

  logic                push, pop, wr_en;

  // Handshake outputs depend on registered state only, never on valid_i/yumi_i.
  assign ready_o   = (count_q != depth_lp);
  assign valid_o   = (count_q != '0);
  assign data_o    = mem_q[rd_ptr_q];
  assign count_o   = count_q;
  assign afull_o   = afull_q;
  assign aempty_o  = aempty_q;
  assign err_ovf_o = err_ovf_q;
  assign err_unf_o = err_unf_q;

  assign push  = valid_i & ready_o;
  assign pop   = yumi_i & valid_o;
  assign wr_en = push & ~flush_i;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    err_ovf_d = err_ovf_q;
    err_unf_d = err_unf_q;

    if (flush_i) begin
      // Flush wins over everything: the handshakes of this cycle are dropped and
      // do not count as protocol errors.
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      err_ovf_d = 1'b0;
      err_unf_d = 1'b0;
    end else begin
      // Explicit wrap keeps the pointers modulo depth_p for non-power-of-two depths.
      if (push) wr_ptr_d = (wr_ptr_q == last_ptr_lp) ? '0 : wr_ptr_q + ptr_w_lp'(1);
      if (pop)  rd_ptr_d = (rd_ptr_q == last_ptr_lp) ? '0 : rd_ptr_q + ptr_w_lp'(1);

      case ({push, pop})
        2'b10:   count_d = count_q + cnt_w_lp'(1);
        2'b01:   count_d = count_q - cnt_w_lp'(1);
        default: count_d = count_q;
      endcase

      err_ovf_d = err_ovf_q | (valid_i & ~ready_o);
      err_unf_d = err_unf_q | (yumi_i & ~valid_o);
    end

    // Flags come from the next count, so they line up with count_o every cycle.
    afull_d  = (count_d >= afull_lp);
    aempty_d = (count_d <= aempty_lp);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      afull_q   <= (afull_lvl_p == 0);
      aempty_q  <= 1'b1;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      afull_q   <= afull_d;
      aempty_q  <= aempty_d;
      err_ovf_q <= err_ovf_d;
      err_unf_q <= err_unf_d;
    end
  end

  // NOTE: storage has no reset; contents are only observable while valid_o=1,
  // and a reset-free array maps onto LUT RAM.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: tb/tb_fifo_counted.sv
// Testbench for fifo_counted (depth 5, afull at 4, aempty at 1). Expected read data
// is queued when a legal push is issued; a monitor pops and compares whenever the
// consumer takes a word.
module tb_fifo_counted;

  localparam int width_p = 8;
  localparam int depth_p = 5;

  logic               clk_i = 1'b0;
  logic               reset_i;
  logic               flush_i;
  logic               ready_o;
  logic               valid_i;
  logic [width_p-1:0] data_i;
  logic               valid_o;
  logic [width_p-1:0] data_o;
  logic               yumi_i;
  logic [2:0]         count_o;
  logic               afull_o;
  logic               aempty_o;
  logic               err_ovf_o;
  logic               err_unf_o;

  int n_tests = 0;
  int n_fails = 0;

  logic [width_p-1:0] sb [$];

  fifo_counted #(
    .width_p     (width_p),
    .depth_p     (depth_p),
    .afull_lvl_p (4),
    .aempty_lvl_p(1)
  ) dut (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .flush_i  (flush_i),
    .ready_o  (ready_o),
    .valid_i  (valid_i),
    .data_i   (data_i),
    .valid_o  (valid_o),
    .data_o   (data_o),
    .yumi_i   (yumi_i),
    .count_o  (count_o),
    .afull_o  (afull_o),
    .aempty_o (aempty_o),
    .err_ovf_o(err_ovf_o),
    .err_unf_o(err_unf_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus; returns 1 time unit after the next rising edge.
  task automatic drive(input logic v, input logic [width_p-1:0] d, input logic y);
    valid_i = v;
    data_i  = d;
    yumi_i  = y;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    yumi_i  = 1'b0;
  endtask

  // Monitor: compare every word the consumer takes against the scoreboard.
  always @(negedge clk_i) begin
    if (!reset_i && !flush_i && valid_o && yumi_i) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fails++;
        $display("FAIL pop_unexpected: got 0x%0h, expected no word (t=%0t)", data_o, $time);
      end else begin
        check("data_o", 32'(data_o), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    reset_i = 1'b1;
    flush_i = 1'b0;
    valid_i = 1'b0;
    yumi_i  = 1'b0;
    data_i  = '0;
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;

    // Reset state.
    check("rst_ready",  32'(ready_o),   32'd1);
    check("rst_valid",  32'(valid_o),   32'd0);
    check("rst_count",  32'(count_o),   32'd0);
    check("rst_afull",  32'(afull_o),   32'd0);
    check("rst_aempty", 32'(aempty_o),  32'd1);
    check("rst_ovf",    32'(err_ovf_o), 32'd0);
    check("rst_unf",    32'(err_unf_o), 32'd0);

    // Back-to-back push of 0x01..0x05 fills the FIFO, then drain in order.
    for (int i = 1; i <= 5; i++) begin
      sb.push_back(8'(i));
      drive(1'b1, 8'(i), 1'b0);
      if (i == 1) begin
        check("lat_valid", 32'(valid_o), 32'd1);
        check("lat_data",  32'(data_o),  32'h01);
      end
    end
    check("full_count", 32'(count_o), 32'd5);
    check("full_ready", 32'(ready_o), 32'd0);
    check("full_afull", 32'(afull_o), 32'd1);
    for (int i = 0; i < 5; i++) drive(1'b0, 8'h00, 1'b1);
    check("drain_count", 32'(count_o), 32'd0);
    check("drain_valid", 32'(valid_o), 32'd0);

    // Step occupancy 0..5 and check both programmable flags at each level.
    for (int c = 0; c <= 5; c++) begin
      check($sformatf("lvl%0d_count", c),  32'(count_o),  32'(c));
      check($sformatf("lvl%0d_aempty", c), 32'(aempty_o), 32'(c <= 1));
      check($sformatf("lvl%0d_afull", c),  32'(afull_o),  32'(c >= 4));
      if (c < 5) begin
        sb.push_back(8'(8'h10 + c));
        drive(1'b1, 8'(8'h10 + c), 1'b0);
      end
    end

    // Push into a full FIFO: refused, sticky overflow set, contents kept.
    drive(1'b1, 8'hEE, 1'b0);
    check("ovf_flag",  32'(err_ovf_o), 32'd1);
    check("ovf_count", 32'(count_o),   32'd5);
    check("ovf_ready", 32'(ready_o),   32'd0);

    // Full with push+pop: only the pop happens.
    drive(1'b1, 8'hEE, 1'b1);
    check("fullpp_count", 32'(count_o), 32'd4);
    check("fullpp_ready", 32'(ready_o), 32'd1);

    // Streaming push+pop for 20 cycles wraps both pointers several times.
    for (int k = 0; k < 20; k++) begin
      sb.push_back(8'(8'h20 + k));
      drive(1'b1, 8'(8'h20 + k), 1'b1);
      check("stream_count", 32'(count_o), 32'd4);
    end
    for (int i = 0; i < 4; i++) drive(1'b0, 8'h00, 1'b1);
    check("stream_empty", 32'(count_o), 32'd0);

    // Pop from empty: refused, sticky underflow set.
    drive(1'b0, 8'h00, 1'b1);
    check("unf_flag",  32'(err_unf_o), 32'd1);
    check("unf_count", 32'(count_o),   32'd0);
    check("unf_ovf",   32'(err_ovf_o), 32'd1);

    // Flush with data inside and a push+pop in the flush cycle.
    sb.push_back(8'h31);
    drive(1'b1, 8'h31, 1'b0);
    sb.push_back(8'h32);
    drive(1'b1, 8'h32, 1'b0);
    flush_i = 1'b1;
    drive(1'b1, 8'h33, 1'b1);
    flush_i = 1'b0;
    sb.delete();
    check("flush_count",  32'(count_o),   32'd0);
    check("flush_valid",  32'(valid_o),   32'd0);
    check("flush_ready",  32'(ready_o),   32'd1);
    check("flush_aempty", 32'(aempty_o),  32'd1);
    check("flush_afull",  32'(afull_o),   32'd0);
    check("flush_ovf",    32'(err_ovf_o), 32'd0);
    check("flush_unf",    32'(err_unf_o), 32'd0);

    // Asynchronous reset with three words inside.
    for (int i = 0; i < 3; i++) drive(1'b1, 8'(8'h41 + i), 1'b0);
    check("pre_rst_count", 32'(count_o), 32'd3);
    #2;
    reset_i = 1'b1;
    #1;
    check("async_rst_valid", 32'(valid_o), 32'd0);
    check("async_rst_count", 32'(count_o), 32'd0);
    #2;
    reset_i = 1'b0;
    @(posedge clk_i);
    #1;
    sb.push_back(8'hAA);
    drive(1'b1, 8'hAA, 1'b0);
    check("post_rst_valid", 32'(valid_o), 32'd1);
    check("post_rst_data",  32'(data_o),  32'hAA);
    check("post_rst_count", 32'(count_o), 32'd1);
    drive(1'b0, 8'h00, 1'b1);
    check("final_count", 32'(count_o), 32'd0);
    check("sb_drained",  32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
